// File: rtl/or1k_tile_reset_seq_pkg.sv
// Shared definitions for the OR1K tile reset sequencer: FSM state encoding
// and the width helpers used to size its counters.
package or1k_tile_reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STAGGER = 2'd1,
        ST_RUN     = 2'd2
    } rst_state_e;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/or1k_tile_reset_seq_stretch.sv
// One core's reset bit: boot hold, release, enable-edge reload and soft-reset
// pulse stretching. rst_d_o exposes the next value so the top can register busy.
module or1k_tile_reset_seq_stretch
    import or1k_tile_reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req_i,
    input  logic hold_i,
    input  logic release_i,
    input  logic run_i,
    output logic rst_d_o,
    output logic rst_o
);

    localparam int SW = cnt_width(HOLD_CYCLES);
    localparam logic [SW-1:0] LOAD = SW'(HOLD_CYCLES);
    localparam logic [SW-1:0] ONE  = SW'(1);

    logic [SW-1:0] cnt_q, cnt_d;
    logic          rst_q, rst_d;
    logic          en_prev_q;

    always_comb begin
        cnt_d = cnt_q;
        rst_d = rst_q;
        if (rst_i || hold_i) begin
            cnt_d = '0;
            rst_d = 1'b1;
        end else if (release_i) begin
            cnt_d = '0;
            rst_d = ~en_i;
        end else if (!en_i) begin
            cnt_d = '0;
            rst_d = 1'b1;
        end else if (!en_prev_q) begin
            cnt_d = LOAD;
            rst_d = 1'b1;
        end else if (req_i && run_i) begin
            // A new request restarts the stretch instead of extending it.
            cnt_d = LOAD;
            rst_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
            if (cnt_q == ONE) begin
                rst_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            rst_q     <= 1'b1;
            en_prev_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rst_q     <= rst_d;
            en_prev_q <= en_i;
        end
    end

    assign rst_d_o = rst_d;
    assign rst_o   = rst_q;

endmodule

// File: rtl/or1k_tile_reset_seq.sv
// Tile reset sequencer: holds the bus in reset, then releases enabled cores one
// by one at a fixed stagger, then services per-core soft resets.
module or1k_tile_reset_seq
    import or1k_tile_reset_seq_pkg::*;
#(
    parameter int CORES          = 8,
    parameter int HOLD_CYCLES    = 10,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [CORES-1:0] core_en_i,
    input  logic [CORES-1:0] core_rst_req_i,
    output logic             bus_rst_o,
    output logic [CORES-1:0] core_rst_o,
    output logic             init_done_o,
    output logic             busy_o
);

    localparam int CW = cnt_width(max_int(HOLD_CYCLES, STAGGER_CYCLES));
    localparam int IW = idx_width(CORES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(CORES - 1);

    rst_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_inc;
    logic [IW-1:0]    idx_q;
    logic             bus_rst_q;
    logic             init_done_q;
    logic             busy_q;
    logic             stag_hit;
    logic             run;
    logic [CORES-1:0] core_rst_d;

    assign cnt_inc  = cnt_q + CW'(1);
    assign stag_hit = (state_q == ST_STAGGER) && (cnt_inc == STAG_LAST);
    assign run      = (state_q == ST_RUN);

    for (genvar g = 0; g < CORES; g++) begin : g_core
        logic rel;
        logic hold;

        // Cores at or beyond idx have not been reached by the stagger yet.
        assign rel  = stag_hit && (idx_q == IW'(g));
        assign hold = !run && (IW'(g) >= idx_q) && !rel;

        or1k_tile_reset_seq_stretch #(
            .HOLD_CYCLES(HOLD_CYCLES)
        ) u_stretch (
            .clk_i    (wb_clk_i),
            .rst_i    (wb_rst_i),
            .en_i     (core_en_i[g]),
            .req_i    (core_rst_req_i[g]),
            .hold_i   (hold),
            .release_i(rel),
            .run_i    (run),
            .rst_d_o  (core_rst_d[g]),
            .rst_o    (core_rst_o[g])
        );
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            bus_rst_q   <= 1'b1;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_inc == HOLD_LAST) begin
                        bus_rst_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= ST_STAGGER;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_STAGGER: begin
                    if (stag_hit) begin
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q     <= ST_RUN;
                            init_done_q <= 1'b1;
                            busy_q      <= |(core_rst_d & core_en_i);
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_RUN: begin
                    busy_q <= |(core_rst_d & core_en_i);
                end
                default: begin
                    state_q <= ST_HOLD;
                end
            endcase
        end
    end

    assign bus_rst_o   = bus_rst_q;
    assign init_done_o = init_done_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_or1k_tile_reset_seq.sv
// Self-checking bench for or1k_tile_reset_seq: directed boot/run scenarios and
// randomized traffic against a timeline-based reference model.
module tb_or1k_tile_reset_seq;

    localparam int CORES  = 8;
    localparam int HOLD   = 10;
    localparam int STAG   = 4;
    localparam int T_LAST = HOLD + STAG * CORES;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CORES-1:0] en  = '1;
    logic [CORES-1:0] req = '0;
    logic             bus_rst_o;
    logic [CORES-1:0] core_rst_o;
    logic             init_done_o;
    logic             busy_o;

    int total = 0;
    int bad   = 0;

    // Model: t counts edges since reset released; a core is in reset while it
    // has not reached its release time, is disabled, or is inside a stretch window.
    int               t = 0;
    int               until_m[CORES];
    logic [CORES-1:0] en_prev_m = '0;
    logic             exp_bus;
    logic [CORES-1:0] exp_core;
    logic             exp_init;
    logic             exp_busy;

    always #5 clk = ~clk;

    or1k_tile_reset_seq #(
        .CORES(CORES),
        .HOLD_CYCLES(HOLD),
        .STAGGER_CYCLES(STAG)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .core_en_i     (en),
        .core_rst_req_i(req),
        .bus_rst_o     (bus_rst_o),
        .core_rst_o    (core_rst_o),
        .init_done_o   (init_done_o),
        .busy_o        (busy_o)
    );

    task automatic model_edge();
        if (rst) begin
            t = 0;
            for (int k = 0; k < CORES; k++) until_m[k] = 0;
            en_prev_m = '0;
            exp_bus   = 1'b1;
            exp_core  = '1;
            exp_init  = 1'b0;
            exp_busy  = 1'b1;
        end else begin
            t++;
            for (int k = 0; k < CORES; k++) begin
                int rel_t;
                rel_t = HOLD + STAG * (k + 1);
                if (t > rel_t) begin
                    if (!en[k]) until_m[k] = 0;
                    else if (!en_prev_m[k]) until_m[k] = t + HOLD;
                    else if (t > T_LAST && req[k]) until_m[k] = t + HOLD;
                end
                exp_core[k] = (t < rel_t) || !en[k] || (t < until_m[k]);
            end
            en_prev_m = en;
            exp_bus   = (t < HOLD);
            exp_init  = (t >= T_LAST);
            exp_busy  = (t < T_LAST) ? 1'b1 : |(exp_core & en);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s t=%0d got=%b exp=%b", tag, t, got, exp);
        end
    endtask

    task automatic checkv(input string tag, input logic [CORES-1:0] got, input logic [CORES-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s t=%0d got=%b exp=%b", tag, t, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
        check1("bus_rst", bus_rst_o, exp_bus);
        checkv("core_rst", core_rst_o, exp_core);
        check1("init_done", init_done_o, exp_init);
        check1("busy", busy_o, exp_busy);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Boot, all cores enabled.
        rst = 1'b1; en = '1; req = '0;
        steps(2);
        rst = 1'b0;
        steps(60);

        // Single-cycle soft reset on core 3.
        req[3] = 1'b1; step();
        req = '0;      steps(14);

        // Request on core 1, then core 1 and 5 together five edges later.
        req[1] = 1'b1;    step();
        req = '0;         steps(4);
        req = 8'b0010_0010; step();
        req = '0;         steps(14);

        // Enable drop and return on core 2.
        en[2] = 1'b0; steps(10);
        en[2] = 1'b1; steps(15);

        // Held request keeps the core in reset.
        req[6] = 1'b1; steps(6);
        req = '0;      steps(13);

        // Boot with only odd cores enabled.
        rst = 1'b1; en = 8'b1010_1010; step();
        rst = 1'b0; steps(60);

        // Reset pulse in the middle of STAGGER restarts the sequence.
        rst = 1'b1; en = '1; step();
        rst = 1'b0; steps(30);
        rst = 1'b1; step();
        rst = 1'b0; steps(55);

        // Randomized traffic, including enable flips and requests during boot.
        for (int r = 0; r < 6; r++) begin
            rst = 1'b1;
            en  = ($urandom_range(0, 1) == 1) ? '1 : CORES'($urandom);
            req = '0;
            step();
            rst = 1'b0;
            for (int c = 0; c < 250; c++) begin
                int j;
                req = '0;
                if ($urandom_range(0, 3) == 0) req = CORES'($urandom) & CORES'($urandom);
                if ($urandom_range(0, 15) == 0) begin
                    j = $urandom_range(0, CORES - 1);
                    en[j] = ~en[j];
                end
                rst = ($urandom_range(0, 299) == 0);
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
